// File: rtl/pc_ctrl_if.sv
// Signal bundle between the PC controller and the rest of the Y86-64 pipeline:
// fetch results, hazard sources, redirect requests and the stall/bubble controls.
interface pc_ctrl_if;
    // Fetch-stage results for the PC currently presented
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_in_mem;
    logic        f_in_inst;
    logic        f_hlt;

    // Hazard sources from decode and execute
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  e_icode;
    logic [3:0]  e_dstM;

    // Redirect requests
    logic        ex_mispredict;
    logic [63:0] ex_fallthru;
    logic        ret_valid;
    logic [63:0] ret_addr;

    // Status of the instruction retiring in writeback
    logic [1:0]  w_stat;

    // Controller outputs
    logic [63:0] pc;
    logic        f_stall;
    logic        d_stall;
    logic        d_bubble;
    logic        e_bubble;
    logic [1:0]  stat;
    logic        halted;

    // Pipeline side: drives stage results, consumes PC and controls
    modport master (
        output f_icode, f_valC, f_valP, f_in_mem, f_in_inst, f_hlt,
        output d_srcA, d_srcB, e_icode, e_dstM,
        output ex_mispredict, ex_fallthru, ret_valid, ret_addr, w_stat,
        input  pc, f_stall, d_stall, d_bubble, e_bubble, stat, halted
    );

    // Controller side
    modport slave (
        input  f_icode, f_valC, f_valP, f_in_mem, f_in_inst, f_hlt,
        input  d_srcA, d_srcB, e_icode, e_dstM,
        input  ex_mispredict, ex_fallthru, ret_valid, ret_addr, w_stat,
        output pc, f_stall, d_stall, d_bubble, e_bubble, stat, halted
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller for the pipelined Y86-64 core. Holds the predicted
// PC, selects the fetch PC, detects load-use hazards and sequences ret refill,
// fetch-exception drain and halt through a small state machine.
module pc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_ctrl_if.slave   bus
);

    localparam logic [3:0] ICODE_MRMOV = 4'd5;
    localparam logic [3:0] ICODE_JXX   = 4'd7;
    localparam logic [3:0] ICODE_CALL  = 4'd8;
    localparam logic [3:0] ICODE_RET   = 4'd9;
    localparam logic [3:0] ICODE_POPQ  = 4'd11;
    localparam logic [3:0] REG_NONE    = 4'hF;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pred_pc_reg, pred_pc_next;
    logic [1:0]  stat_reg, stat_next;

    logic        load_use;
    logic        fetch_exc;
    logic [63:0] pc_sel;
    logic        f_stall_c, d_stall_c, d_bubble_c, e_bubble_c, halted_c;

    // Hazard and exception detection from the current stage contents
    always_comb begin
        load_use  = ((bus.e_icode == ICODE_MRMOV) || (bus.e_icode == ICODE_POPQ)) &&
                    (bus.e_dstM != REG_NONE) &&
                    ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));
        fetch_exc = bus.f_in_mem | bus.f_in_inst | bus.f_hlt;
    end

    // Fetch PC select: mispredict beats ret refill beats prediction
    always_comb begin
        if (bus.ex_mispredict) begin
            pc_sel = bus.ex_fallthru;
        end else if (bus.ret_valid) begin
            pc_sel = bus.ret_addr;
        end else begin
            pc_sel = pred_pc_reg;
        end
    end

    // Next state and pipeline controls; a nonzero writeback status always halts
    always_comb begin
        state_next = state_reg;
        f_stall_c  = 1'b0;
        d_stall_c  = 1'b0;
        d_bubble_c = 1'b0;
        e_bubble_c = 1'b0;
        halted_c   = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.ex_mispredict) begin
                    // Squash the two wrong-path instructions; any stall is dropped
                    d_bubble_c = 1'b1;
                    e_bubble_c = 1'b1;
                end else if (load_use) begin
                    // Hold F and D, insert a bubble into E; nothing new is fetched
                    f_stall_c  = 1'b1;
                    d_stall_c  = 1'b1;
                    e_bubble_c = 1'b1;
                end else if (fetch_exc) begin
                    state_next = DRAIN;
                end else if (bus.f_icode == ICODE_RET) begin
                    state_next = RET_WAIT;
                end
            end
            RET_WAIT: begin
                if (bus.ex_mispredict) begin
                    d_bubble_c = 1'b1;
                    e_bubble_c = 1'b1;
                    state_next = RUN;
                end else if (bus.ret_valid) begin
                    // Return address is on pc this cycle; fetch proceeds normally
                    state_next = RUN;
                end else begin
                    f_stall_c  = 1'b1;
                    d_bubble_c = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.ex_mispredict) begin
                    // The excepting fetch was on the wrong path; resume
                    d_bubble_c = 1'b1;
                    e_bubble_c = 1'b1;
                    state_next = RUN;
                end else begin
                    f_stall_c  = 1'b1;
                    d_bubble_c = 1'b1;
                end
            end
            HALTED: begin
                f_stall_c  = 1'b1;
                d_bubble_c = 1'b1;
                e_bubble_c = 1'b1;
                halted_c   = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (bus.w_stat != 2'd0) begin
            state_next = HALTED;
        end
    end

    // Prediction for the next fetch and status capture on entry to HALTED
    always_comb begin
        if (f_stall_c) begin
            pred_pc_next = pred_pc_reg;
        end else if ((bus.f_icode == ICODE_JXX) || (bus.f_icode == ICODE_CALL)) begin
            pred_pc_next = bus.f_valC;
        end else begin
            pred_pc_next = bus.f_valP;
        end
        if ((state_reg != HALTED) && (bus.w_stat != 2'd0)) begin
            stat_next = bus.w_stat;
        end else begin
            stat_next = stat_reg;
        end
    end

    // State, predicted PC and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            pred_pc_reg <= RESET_PC;
            stat_reg    <= 2'd0;
        end else begin
            state_reg   <= state_next;
            pred_pc_reg <= pred_pc_next;
            stat_reg    <= stat_next;
        end
    end

    // While reset is held the outputs are forced quiet, independent of inputs
    always_comb begin
        bus.pc       = rst_n ? pc_sel : RESET_PC;
        bus.f_stall  = f_stall_c  & rst_n;
        bus.d_stall  = d_stall_c  & rst_n;
        bus.d_bubble = d_bubble_c & rst_n;
        bus.e_bubble = e_bubble_c & rst_n;
        bus.halted   = halted_c   & rst_n;
        bus.stat     = stat_reg;
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a cycle-by-cycle vector table covering sequential
// flow, jump prediction, mispredicts, load-use, ret refill, drain and halt, then
// hand-written sequences for asynchronous reset and halt-vs-mispredict.
module tb_pc_ctrl;

    logic clk;
    logic rst_n;

    pc_ctrl_if bus ();

    pc_ctrl #(.RESET_PC(64'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f_icode;
        logic [63:0] f_valC;
        logic [63:0] f_valP;
        logic [2:0]  flags;      // {in_mem, in_inst, hlt}
        logic [3:0]  d_srcA;
        logic [3:0]  d_srcB;
        logic [3:0]  e_icode;
        logic [3:0]  e_dstM;
        logic        mis;
        logic [63:0] fallthru;
        logic        ret_v;
        logic [63:0] ret_addr;
        logic [1:0]  w_stat;
        logic [63:0] exp_pc;
        logic [4:0]  exp_ctl;    // {f_stall, d_stall, d_bubble, e_bubble, halted}
        logic [1:0]  exp_stat;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(
        input logic [3:0] fi, input logic [63:0] vc, input logic [63:0] vp,
        input logic [2:0] fl, input logic [3:0] sa, input logic [3:0] sb,
        input logic [3:0] ei, input logic [3:0] ed,
        input logic mi, input logic [63:0] ft, input logic rv, input logic [63:0] ra,
        input logic [1:0] ws, input logic [63:0] epc, input logic [4:0] ectl,
        input logic [1:0] est);
        vec_t v;
        v.f_icode = fi; v.f_valC = vc; v.f_valP = vp; v.flags = fl;
        v.d_srcA = sa; v.d_srcB = sb; v.e_icode = ei; v.e_dstM = ed;
        v.mis = mi; v.fallthru = ft; v.ret_v = rv; v.ret_addr = ra; v.w_stat = ws;
        v.exp_pc = epc; v.exp_ctl = ectl; v.exp_stat = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        bus.f_icode = 4'd1; bus.f_valC = 64'd0; bus.f_valP = 64'd0;
        bus.f_in_mem = 1'b0; bus.f_in_inst = 1'b0; bus.f_hlt = 1'b0;
        bus.d_srcA = 4'hF; bus.d_srcB = 4'hF; bus.e_icode = 4'd1; bus.e_dstM = 4'hF;
        bus.ex_mispredict = 1'b0; bus.ex_fallthru = 64'd0;
        bus.ret_valid = 1'b0; bus.ret_addr = 64'd0; bus.w_stat = 2'd0;
    endtask

    task automatic apply(input vec_t v);
        bus.f_icode = v.f_icode; bus.f_valC = v.f_valC; bus.f_valP = v.f_valP;
        {bus.f_in_mem, bus.f_in_inst, bus.f_hlt} = v.flags;
        bus.d_srcA = v.d_srcA; bus.d_srcB = v.d_srcB;
        bus.e_icode = v.e_icode; bus.e_dstM = v.e_dstM;
        bus.ex_mispredict = v.mis; bus.ex_fallthru = v.fallthru;
        bus.ret_valid = v.ret_v; bus.ret_addr = v.ret_addr; bus.w_stat = v.w_stat;
    endtask

    function automatic logic [4:0] ctl();
        return {bus.f_stall, bus.d_stall, bus.d_bubble, bus.e_bubble, bus.halted};
    endfunction

    task automatic check_all(input string tag, input logic [63:0] epc,
                             input logic [4:0] ectl, input logic [1:0] est);
        check({tag, " pc"}, bus.pc, epc);
        check({tag, " ctl"}, {59'd0, ctl()}, {59'd0, ectl});
        check({tag, " stat"}, {62'd0, bus.stat}, {62'd0, est});
        $display("%s pc=%h ctl=%b stat=%0d", tag, bus.pc, ctl(), bus.stat);
    endtask

    localparam logic [3:0] N = 4'hF;

    initial begin
        // fi  valC     valP     flags   sA sB  ei   eD  mis fall     rv ret     ws  pc       ctl        st
        vecs.push_back(mk(4'd6, 64'h0,   64'h2,   3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h0,   5'b00000, 0)); // v0 seq
        vecs.push_back(mk(4'd3, 64'h0,   64'hC,   3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h2,   5'b00000, 0)); // v1
        vecs.push_back(mk(4'd7, 64'h200, 64'h1A,  3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'hC,   5'b00000, 0)); // v2 jXX
        vecs.push_back(mk(4'd6, 64'h0,   64'h202, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h200, 5'b00000, 0)); // v3 predicted
        vecs.push_back(mk(4'd6, 64'h0,   64'h1C,  3'b000, N, N, 4'd1, N, 1, 64'h1A, 0, 64'h0,  0, 64'h1A,  5'b00110, 0)); // v4 mispredict
        vecs.push_back(mk(4'd6, 64'h0,   64'h42,  3'b000, N, N, 4'd1, N, 1, 64'h40, 1, 64'h99, 0, 64'h40,  5'b00110, 0)); // v5 mis beats ret
        vecs.push_back(mk(4'd6, 64'h0,   64'h44,  3'b000, 4'd3, N, 4'd5, 4'd3, 0, 64'h0, 0, 64'h0, 0, 64'h42, 5'b11010, 0)); // v6 load-use A
        vecs.push_back(mk(4'd6, 64'h0,   64'h44,  3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h42,  5'b00000, 0)); // v7 resume
        vecs.push_back(mk(4'd6, 64'h0,   64'h46,  3'b000, N, 4'd4, 4'd11, 4'd4, 0, 64'h0, 0, 64'h0, 0, 64'h44, 5'b11010, 0)); // v8 popq B
        vecs.push_back(mk(4'd6, 64'h0,   64'hC1,  3'b000, N, N, 4'd5, N, 0, 64'h0,  0, 64'h0,  0, 64'h44,  5'b00000, 0)); // v9 dstM none
        vecs.push_back(mk(4'd6, 64'h0,   64'hC1,  3'b100, 4'd2, N, 4'd5, 4'd2, 1, 64'hB0, 0, 64'h0, 0, 64'hB0, 5'b00110, 0)); // v10 mis+lu+exc
        vecs.push_back(mk(4'd9, 64'h0,   64'hC2,  3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'hC1,  5'b00000, 0)); // v11 ret
        vecs.push_back(mk(4'd6, 64'h0,   64'h999, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'hC2,  5'b10100, 0)); // v12 ret wait
        vecs.push_back(mk(4'd6, 64'h0,   64'h999, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'hC2,  5'b10100, 0)); // v13
        vecs.push_back(mk(4'd6, 64'h0,   64'h3D,  3'b000, N, N, 4'd1, N, 0, 64'h0,  1, 64'h3B, 0, 64'h3B,  5'b00000, 0)); // v14 ret_valid
        vecs.push_back(mk(4'd6, 64'h0,   64'h3F,  3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h3D,  5'b00000, 0)); // v15 run
        vecs.push_back(mk(4'd7, 64'h200, 64'h48,  3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h3F,  5'b00000, 0)); // v16 jXX
        vecs.push_back(mk(4'd1, 64'h0,   64'h201, 3'b010, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h200, 5'b00000, 0)); // v17 in_inst
        vecs.push_back(mk(4'd6, 64'h0,   64'h300, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h201, 5'b10100, 0)); // v18 drain
        vecs.push_back(mk(4'd6, 64'h0,   64'h1C,  3'b000, N, N, 4'd1, N, 1, 64'h1A, 0, 64'h0,  0, 64'h1A,  5'b00110, 0)); // v19 cancel
        vecs.push_back(mk(4'd6, 64'h0,   64'h1E,  3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h1C,  5'b00000, 0)); // v20 run
        vecs.push_back(mk(4'd0, 64'h0,   64'h1F,  3'b001, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h1E,  5'b00000, 0)); // v21 hlt
        vecs.push_back(mk(4'd6, 64'h0,   64'h400, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h1F,  5'b10100, 0)); // v22 drain
        vecs.push_back(mk(4'd6, 64'h0,   64'h400, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h1F,  5'b10100, 0)); // v23
        vecs.push_back(mk(4'd6, 64'h0,   64'h400, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  1, 64'h1F,  5'b10100, 0)); // v24 w_stat
        vecs.push_back(mk(4'd6, 64'h0,   64'h400, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h1F,  5'b10111, 1)); // v25 halted
        vecs.push_back(mk(4'd6, 64'h0,   64'h400, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  3, 64'h1F,  5'b10111, 1)); // v26 no recapture
        vecs.push_back(mk(4'd6, 64'h0,   64'h400, 3'b000, N, N, 4'd1, N, 0, 64'h0,  0, 64'h0,  0, 64'h1F,  5'b10111, 1)); // v27

        // Reset held: outputs quiet even with a mispredict and load-use presented
        idle();
        rst_n = 1'b0;
        bus.ex_mispredict = 1'b1; bus.ex_fallthru = 64'h55;
        bus.e_icode = 4'd5; bus.e_dstM = 4'd3; bus.d_srcA = 4'd3;
        @(negedge clk);
        check_all("reset", 64'h0, 5'b00000, 2'd0);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven cycles: inputs settle after the edge, outputs checked at negedge
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_ctl, vecs[i].exp_stat);
            @(posedge clk); #1;
        end

        // Asynchronous reset while HALTED, with redirect and hazard inputs active
        bus.ex_mispredict = 1'b1; bus.ex_fallthru = 64'h77;
        bus.e_icode = 4'd5; bus.e_dstM = 4'd3; bus.d_srcA = 4'd3;
        #2 rst_n = 1'b0;
        #1 check_all("async_rst_halted", 64'h0, 5'b00000, 2'd0);
        idle();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Enter RET_WAIT, then reset mid-wait
        bus.f_icode = 4'd9; bus.f_valP = 64'h2;
        @(negedge clk);
        check_all("ret_fetch", 64'h0, 5'b00000, 2'd0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check_all("ret_wait", 64'h2, 5'b10100, 2'd0);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst_retwait", 64'h0, 5'b00000, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.f_icode = 4'd6; bus.f_valP = 64'h4;
        @(negedge clk);
        check_all("after_rst", 64'h0, 5'b00000, 2'd0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check_all("after_rst_run", 64'h4, 5'b00000, 2'd0);

        // Nonzero w_stat together with a mispredict: halt wins, status captured
        @(posedge clk); #1;
        bus.ex_mispredict = 1'b1; bus.ex_fallthru = 64'h30; bus.w_stat = 2'd2;
        @(negedge clk);
        check_all("halt_vs_mis", 64'h30, 5'b00110, 2'd0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check_all("halt_vs_mis_next", 64'h0, 5'b10111, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter controller for the pipelined Y86-64 core: owns the predicted-PC register and picks the PC presented to the fetch stage each cycle. It detects load-use hazards and handles branch mispredicts, `ret` refill and fetch-stage exceptions. It drives stall/bubble controls to the F, D and E pipeline registers and the architectural status.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded at reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- f_icode  in  4  icode decoded by fetch at current `pc`
- f_valC  in  64  constant word from fetch
- f_valP  in  64  fall-through address from fetch
- f_in_mem, f_in_inst, f_hlt  in  1 each  fetch exception flags
- d_srcA, d_srcB  in  4 each  source registers of instruction in decode (4'hF = none)
- e_icode  in  4  icode in execute
- e_dstM  in  4  memory-destination register in execute
- ex_mispredict  in  1  jXX in execute resolved not-taken
- ex_fallthru  in  64  correct PC for a mispredict
- ret_valid  in  1  `ret` has read its return address (memory-stage result valid)
- ret_addr  in  64  return address
- w_stat  in  2  status of instruction retiring in writeback (0 AOK, 1 HLT, 2 ADR, 3 INS)
- pc  out  64  PC to fetch (combinational)
- f_stall, d_stall, d_bubble, e_bubble  out  1 each  pipeline register controls
- stat  out  2  architectural status, same encoding as w_stat
- halted  out  1  core stopped

## Operation
State machine states: RUN, RET_WAIT, DRAIN, HALTED.

PC select priority:
- ex_mispredict: ex_fallthru.
- Otherwise ret_valid: ret_addr.
- Otherwise predPC.

predPC update:
- Updated at each edge unless f_stall.
- New value is f_valC when f_icode is 7 (jXX) or 8 (call); otherwise f_valP.

Load-use hazard:
- Condition: e_icode in {5 mrmov, 11 popq}, e_dstM != 4'hF, and e_dstM equals d_srcA or d_srcB.
- Response: f_stall=1, d_stall=1, e_bubble=1.

Mispredict:
- d_bubble=1 and e_bubble=1.
- Overrides load-use: the stalls are not asserted; the bubbles are.
- From RET_WAIT or DRAIN, next state is RUN (wrong-path work cancelled).

RUN:
- f_icode==9 (ret) with no mispredict moves to RET_WAIT.
- Any fetch exception flag with no mispredict moves to DRAIN.

RET_WAIT:
- f_stall=1 and d_bubble=1 every cycle; predPC frozen.
- ret_valid: pc=ret_addr, stalls drop that cycle, predPC loads from the fetch of ret_addr, next state RUN.

DRAIN:
- f_stall=1 and d_bubble=1; no new instructions enter.
- Waits for ex_mispredict (go to RUN) or nonzero w_stat (go to HALTED).

HALTED:
- f_stall=1, d_bubble=1, e_bubble=1; halted=1.
- stat holds the captured w_stat; only rst_n exits this state.

stat:
- Registered; 0 until the first nonzero w_stat, captured at the edge entering HALTED.
- w_stat nonzero in any state forces HALTED.

Width rules: all PC arithmetic is performed by fetch; this block only selects, with no truncation.

## Timing
- Reset (async, rst_n=0): predPC=RESET_PC, state RUN, stat=0.
- Outputs while rst_n=0: pc=RESET_PC regardless of other inputs, all stall/bubble=0, halted=0.
- pc and the stall/bubble outputs are combinational from current inputs and state; predPC, state and stat change only on rising clk.
- Zero-cycle latency from ex_mispredict/ret_valid to pc.
- One-cycle latency from fetch outputs to predPC.
- `ret` costs exactly the cycles until ret_valid, plus 0 on the ret_valid cycle.
- Simultaneous ex_mispredict and ret_valid: mispredict wins; ret_valid ignored.
- Simultaneous ex_mispredict and fetch exception: no DRAIN entry.
- Simultaneous w_stat!=0 and ex_mispredict: HALTED wins.
- Reset asserted mid-RET_WAIT/DRAIN: immediate return to RUN with predPC=RESET_PC.

## Test plan
- Sequential flow: reset, fetch returns f_icode=6, f_valP=2, then f_icode=3, f_valP=12 -> pc 0, 2, 12 on consecutive cycles; no stalls.
- Jump predict and mispredict:
  - f_icode=7, f_valC=0x200, f_valP=0x1A -> next pc=0x200.
  - Two cycles later ex_mispredict=1, ex_fallthru=0x1A -> pc=0x1A same cycle; d_bubble=e_bubble=1.
- Load-use: e_icode=5, e_dstM=3, d_srcA=3 -> f_stall=d_stall=e_bubble=1; pc unchanged for that cycle; resumes next cycle once e_icode is a bubble.
- Ret:
  - f_icode=9 at pc=0xC1 -> RET_WAIT; d_bubble=1 each cycle.
  - ret_valid=1, ret_addr=0x3B on third cycle -> pc=0x3B; state RUN next edge.
- Exceptions and reset:
  - f_hlt=1 -> DRAIN.
  - w_stat=1 three cycles later -> halted=1, stat=1, all bubbles held.
  - rst_n pulse low -> pc=0, stat=0, halted=0 immediately.
- Cancelled exception: f_in_inst=1 at 0x200 -> DRAIN; ex_mispredict=1 with ex_fallthru=0x1A -> RUN; pc=0x1A; stat stays 0.
